// File: rtl/key_bcd_counter.sv
// Two debounced push-buttons driving a 00..59 BCD up/down counter with
// wrap pulses and seven-segment decode of both digits.
module key_bcd_counter #(
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input  logic       clk,
   input  logic       _rst,
   input  logic       _key_inc,
   input  logic       _key_dec,
   input  logic       en,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry,
   output logic       borrow,
   output logic [6:0] seg_tens,
   output logic [6:0] seg_ones
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0] raw_keys;
   logic [1:0] press_evt;   // index 0 = inc, 1 = dec

   assign raw_keys = {_key_dec, _key_inc};

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_key
      logic             sync_p0, sync_p1;
      logic             db_lvl, db_lvl_d;
      logic [CNT_W-1:0] db_cnt;
      logic             evt_p0, evt_p1;

      // Stage boundary: synchronizer -> debouncer -> falling-edge event, two-stage event pipe
      always_ff @(posedge clk or negedge _rst) begin
         if (!_rst) begin
            sync_p0  <= 1'b1;
            sync_p1  <= 1'b1;
            db_lvl   <= 1'b1;
            db_lvl_d <= 1'b1;
            db_cnt   <= '0;
            evt_p0   <= 1'b0;
            evt_p1   <= 1'b0;
         end else begin
            sync_p0  <= raw_keys[k];
            sync_p1  <= sync_p0;
            db_lvl_d <= db_lvl;
            evt_p0   <= db_lvl_d & ~db_lvl;
            evt_p1   <= evt_p0;
            if (sync_p1 == db_lvl) begin
               db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
               db_lvl <= sync_p1;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + CNT_W'(1);
            end
         end
      end

      assign press_evt[k] = evt_p1;
   end

   // Stage boundary: events consumed into the registered BCD digits
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         tens   <= 4'd0;
         ones   <= 4'd0;
         carry  <= 1'b0;
         borrow <= 1'b0;
      end else begin
         carry  <= 1'b0;
         borrow <= 1'b0;
         if (en && (press_evt[0] ^ press_evt[1])) begin
            if (press_evt[0]) begin
               if (ones >= 4'd9) begin
                  ones <= 4'd0;
                  if (tens >= 4'd5) begin
                     tens  <= 4'd0;
                     carry <= 1'b1;
                  end else begin
                     tens <= tens + 4'd1;
                  end
               end else begin
                  ones <= ones + 4'd1;
               end
            end else begin
               if (ones == 4'd0 || ones > 4'd9) begin
                  ones <= 4'd9;
                  if (tens == 4'd0 || tens > 4'd5) begin
                     tens   <= 4'd5;
                     borrow <= 1'b1;
                  end else begin
                     tens <= tens - 4'd1;
                  end
               end else begin
                  ones <= ones - 4'd1;
               end
            end
         end
      end
   end

   assign seg_tens = bcd_to_seg(tens);
   assign seg_ones = bcd_to_seg(ones);

endmodule

// File: tb/tb_key_bcd_counter.sv
// Bench for key_bcd_counter: directed timing/boundary steps plus random key
// presses compared against a modulo-60 reference count.
module tb_key_bcd_counter;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       _rst = 1'b0;
   logic       _key_inc = 1'b1;
   logic       _key_dec = 1'b1;
   logic       en = 1'b1;
   logic [3:0] tens, ones;
   logic       carry, borrow;
   logic [6:0] seg_tens, seg_ones;

   int checks = 0;
   int failures = 0;
   int model_val = 0;

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   key_bcd_counter #(.DEBOUNCE_CYCLES(N)) dut (
      .clk      (clk),
      ._rst     (_rst),
      ._key_inc (_key_inc),
      ._key_dec (_key_dec),
      .en       (en),
      .tens     (tens),
      .ones     (ones),
      .carry    (carry),
      .borrow   (borrow),
      .seg_tens (seg_tens),
      .seg_ones (seg_ones)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_display(input string tag, input int v);
      chk({tag, "_tens"}, int'(tens), v / 10);
      chk({tag, "_ones"}, int'(ones), v % 10);
      chk({tag, "_seg_tens"}, int'(seg_tens), int'(seg_tab[v / 10]));
      chk({tag, "_seg_ones"}, int'(seg_ones), int'(seg_tab[v % 10]));
   endtask

   // One key action; carry/borrow pulses are tallied over the whole window
   // and compared with what a modulo-60 counter would produce.
   task automatic press(input bit do_inc, input bit do_dec, input int hold, input string tag);
      int nc, nb, nboth, exp_c, exp_b, next_v;
      bit act;
      nc = 0; nb = 0; nboth = 0;
      @(negedge clk);
      if (do_inc) _key_inc = 1'b0;
      if (do_dec) _key_dec = 1'b0;
      for (int i = 0; i < hold + 16; i++) begin
         @(negedge clk);
         if (i == hold - 1) begin
            _key_inc = 1'b1;
            _key_dec = 1'b1;
         end
         nc += int'(carry);
         nb += int'(borrow);
         nboth += int'(carry & borrow);
      end
      act = en && (do_inc != do_dec);
      next_v = model_val;
      exp_c = 0; exp_b = 0;
      if (act && do_inc) begin
         next_v = (model_val + 1) % 60;
         exp_c = (model_val == 59) ? 1 : 0;
      end else if (act && do_dec) begin
         next_v = (model_val + 59) % 60;
         exp_b = (model_val == 0) ? 1 : 0;
      end
      model_val = next_v;
      chk_display(tag, model_val);
      chk({tag, "_carry_pulses"}, nc, exp_c);
      chk({tag, "_borrow_pulses"}, nb, exp_b);
      chk({tag, "_carry_and_borrow"}, nboth, 0);
   endtask

   initial begin
      int kind, hold, n;

      // Reset held: everything zero, segments show 0
      repeat (3) @(negedge clk);
      chk_display("in_reset", 0);
      chk("in_reset_carry", int'(carry), 0);
      chk("in_reset_borrow", int'(borrow), 0);
      _rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_display("after_reset", 0);

      // Clean 20-cycle hold: ones changes after edge N+4, exactly once
      _key_inc = 1'b0;
      repeat (N + 4) @(negedge clk);
      chk("latency_before", int'(ones), 0);
      @(negedge clk);
      chk("latency_after", int'(ones), 1);
      repeat (20 - (N + 5)) @(negedge clk);
      _key_inc = 1'b1;
      repeat (20) @(negedge clk);
      model_val = 1;
      chk_display("single_event", 1);

      // Glitch train: 3 low / 1 high, ten times
      for (int i = 0; i < 10; i++) begin
         _key_inc = 1'b0;
         repeat (3) @(negedge clk);
         _key_inc = 1'b1;
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      chk_display("glitch_train", model_val);

      press(1'b0, 1'b1, 8, "dec_to_00");
      for (int i = 0; i < 59; i++) press(1'b1, 1'b0, 8, "preload");
      chk_display("at_59", 59);
      press(1'b1, 1'b0, 8, "wrap_59_00");
      chk("wrap_seg_tens", int'(seg_tens), 'h3F);
      chk("wrap_seg_ones", int'(seg_ones), 'h3F);
      press(1'b0, 1'b1, 8, "wrap_00_59");
      press(1'b1, 1'b0, 8, "back_to_00");
      for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 8, "to_10");
      press(1'b0, 1'b1, 8, "dec_10_09");
      chk_display("at_09", 9);

      press(1'b1, 1'b1, 8, "both_keys");
      en = 1'b0;
      press(1'b1, 1'b0, 8, "en_low");
      en = 1'b1;
      press(1'b1, 1'b0, 8, "en_high");

      // Random mix of inc / dec / both / disabled presses
      for (int i = 0; i < 24; i++) begin
         kind = int'($urandom_range(0, 4));
         hold = int'($urandom_range(N + 3, N + 12));
         en = (kind != 4);
         case (kind)
            0, 1:    press(1'b1, 1'b0, hold, "rand_inc");
            2:       press(1'b0, 1'b1, hold, "rand_dec");
            3:       press(1'b1, 1'b1, hold, "rand_both");
            default: press(($urandom_range(0, 1) == 1), 1'b1, hold, "rand_disabled");
         endcase
      end
      en = 1'b1;

      // Reach 37, then reset between edges with a key mid-debounce
      n = (37 - model_val + 60) % 60;
      for (int i = 0; i < n; i++) press(1'b1, 1'b0, 8, "to_37");
      chk_display("at_37", 37);
      @(negedge clk);
      _key_inc = 1'b0;
      repeat (2) @(posedge clk);
      #2 _rst = 1'b0;
      #1;
      chk_display("async_reset", 0);
      chk("async_reset_carry", int'(carry), 0);
      chk("async_reset_borrow", int'(borrow), 0);
      repeat (3) @(negedge clk);
      _rst = 1'b1;
      repeat (N + 4) @(negedge clk);
      chk("held_release_before", int'(ones), 0);
      @(negedge clk);
      chk("held_release_after", int'(ones), 1);
      repeat (10) @(negedge clk);
      _key_inc = 1'b1;
      repeat (20) @(negedge clk);
      model_val = 1;
      chk_display("held_release_once", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
